// File: rtl/group_serial_subtractor.sv
// group_serial_subtractor
//
// Multi-cycle unsigned subtractor: D = A - B - Bin (mod 2^WIDTH).
// The block processes GROUP bits per cycle, starting with the least significant group.
// Each group ripples the borrow through per-bit generate/propagate terms.
// A group-level skip passes the incoming borrow straight through when every bit propagates.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   A, B, Bin  minuend, subtrahend, borrow-in; sampled on the input handshake
//   in_valid   operands valid
//   in_ready   block idle and able to accept operands
//   D          difference; held until overwritten by the next operation
//   Bout       borrow-out; 1 iff A < B + Bin
//   Zero       1 iff D == 0
//   out_valid  D/Bout/Zero valid
//   out_ready  sink accepts result
module group_serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WIDTH:1] A,
    input  logic [WIDTH:1] B,
    input  logic           Bin,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [WIDTH:1] D,
    output logic           Bout,
    output logic           Zero,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int unsigned NGROUPS = WIDTH / GROUP;
    localparam int unsigned GIDX_W  = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [GIDX_W-1:0] LAST_GRP = GIDX_W'(NGROUPS - 1);

    if ((WIDTH % GROUP) != 0) begin : g_width_check
        $error("group_serial_subtractor: WIDTH must be a multiple of GROUP");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    d_q, d_d;
    logic                brw_q, brw_d;
    logic [GIDX_W-1:0]   grp_q, grp_d;
    logic                bout_q, bout_d;
    logic                zero_q, zero_d;

    // Current-group datapath
    logic [GROUP-1:0]    a_grp, b_grp;
    logic [GROUP-1:0]    gb, pb, diff;
    logic                ripple;
    logic                grp_bout;

    assign a_grp = a_q[grp_q*GROUP +: GROUP];
    assign b_grp = b_q[grp_q*GROUP +: GROUP];

    always_comb begin
        gb     = '0;
        pb     = '0;
        diff   = '0;
        ripple = brw_q;
        for (int unsigned i = 0; i < GROUP; i++) begin
            gb[i]   = ~a_grp[i] & b_grp[i];
            pb[i]   = ~(a_grp[i] ^ b_grp[i]);
            diff[i] = a_grp[i] ^ b_grp[i] ^ ripple;
            ripple  = gb[i] | (pb[i] & ripple);
        end
        // When every bit propagates, the group borrow-out equals its borrow-in.
        grp_bout = (&pb) ? brw_q : ripple;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        brw_d   = brw_q;
        grp_d   = grp_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    grp_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                d_d[grp_q*GROUP +: GROUP] = diff;
                brw_d = grp_bout;
                if (grp_q == LAST_GRP) begin
                    state_d = DONE;
                    bout_d  = grp_bout;
                    // The flag uses the fully assembled difference, including the group just written.
                    zero_d  = (d_d == '0);
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            brw_q   <= 1'b0;
            grp_q   <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            brw_q   <= brw_d;
            grp_q   <= grp_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = d_q;
    assign Bout      = bout_q;
    assign Zero      = zero_q;

endmodule
